// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Imported by the top so the FSM encoding and default width live in one place.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_sub1.sv
// One-bit combinational full subtractor: diff = a - b - bin, with borrow out.
// The borrow flip-flop that closes the loop lives in the parent.
module full_sub1 (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial subtractor: one full-subtractor cell walks the operands LSB first,
// with a start/done handshake and registered result outputs.
module serial_sub8
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] opA_q;
    logic [WIDTH-1:0] opB_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] dOut_q;
    logic [CW-1:0]    count_q;
    logic             borrow_q;
    logic             borrowOut_q;
    logic             busy_q;
    logic             done_q;
    logic             diffBit;
    logic             borrowNext;

    full_sub1 u_cell (
        .a    (opA_q[0]),
        .b    (opB_q[0]),
        .bin  (borrow_q),
        .diff (diffBit),
        .bout (borrowNext)
    );

    // The result fills from the MSB end so the last bit lands in position WIDTH-1.
    assign result_d = {diffBit, result_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            opA_q       <= '0;
            opB_q       <= '0;
            result_q    <= '0;
            dOut_q      <= '0;
            count_q     <= '0;
            borrow_q    <= 1'b0;
            borrowOut_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        opA_q    <= x;
                        opB_q    <= y;
                        borrow_q <= borrow_in;
                        count_q  <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    opA_q    <= opA_q >> 1;
                    opB_q    <= opB_q >> 1;
                    borrow_q <= borrowNext;
                    result_q <= result_d;
                    // The counter stops at the last bit so it never wraps mid-operation.
                    if (count_q == LAST_BIT) begin
                        dOut_q      <= result_d;
                        borrowOut_q <= borrowNext;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign d          = dOut_q;
    assign borrow_out = borrowOut_q;

endmodule

// File: tb/tb_serial_sub8.sv
// Testbench for serial_sub8: directed scenarios plus randomized operands
// checked against plain integer subtraction.
module tb_serial_sub8;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] x;
    logic [7:0] y;
    logic       borrow_in;
    logic       busy;
    logic       done;
    logic [7:0] d;
    logic       borrow_out;

    int passCount  = 0;
    int checkCount = 0;

    serial_sub8 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .x          (x),
        .y          (y),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .d          (d),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: unsigned integer subtraction.
    function automatic logic [7:0] refDiff(input int xv, input int yv, input int bv);
        int r;
        r = xv - yv - bv;
        if (r < 0) r = r + 256;
        return 8'(r);
    endfunction

    function automatic logic refBorrow(input int xv, input int yv, input int bv);
        return (xv < yv + bv) ? 1'b1 : 1'b0;
    endfunction

    // Issues one operation from IDLE, waits (bounded) for done, then one more edge back to IDLE.
    task automatic doOp(input logic [7:0] xv, input logic [7:0] yv, input logic bv,
                        output int lat, output logic busyAtStart, output logic doneAtStart);
        x = xv; y = yv; borrow_in = bv; start = 1'b1;
        @(posedge clk); #1;
        busyAtStart = busy;
        doneAtStart = done;
        start = 1'b0;
        x = 8'($urandom); y = 8'($urandom); borrow_in = 1'($urandom);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; x = '0; y = '0; borrow_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if ({busy, done, borrow_out, d} !== 11'd0)
            $display("[TB] FAIL reset_state: got busy=%b done=%b bo=%b d=%h, want all zero",
                     busy, done, borrow_out, d);
        else passCount++;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat; logic bs, ds;
        doOp(8'd200, 8'd55, 1'b0, lat, bs, ds);
        checkCount++;
        if (bs !== 1'b1 || ds !== 1'b0)
            $display("[TB] FAIL basic_start_flags: got busy=%b done=%b, want busy=1 done=0", bs, ds);
        else passCount++;
        checkCount++;
        if (lat !== 8) $display("[TB] FAIL basic_latency: got %0d, want 8", lat);
        else passCount++;
        checkCount++;
        if (d !== 8'd145 || borrow_out !== 1'b0)
            $display("[TB] FAIL basic_result: got d=%0d bo=%b, want d=145 bo=0", d, borrow_out);
        else passCount++;
        checkCount++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL basic_idle_after: got busy=%b done=%b, want 0 0", busy, done);
        else passCount++;
    endtask

    task automatic test_midrun_reset();
        int lat; logic bs, ds;
        x = 8'hAA; y = 8'h55; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkCount++;
        if ({busy, done, borrow_out, d} !== 11'd0)
            $display("[TB] FAIL midrun_reset: got busy=%b done=%b bo=%b d=%h, want all zero",
                     busy, done, borrow_out, d);
        else passCount++;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        doOp(8'd9, 8'd3, 1'b0, lat, bs, ds);
        checkCount++;
        if (lat !== 8 || d !== 8'd6 || borrow_out !== 1'b0)
            $display("[TB] FAIL after_reset_op: got lat=%0d d=%0d bo=%b, want 8 6 0", lat, d, borrow_out);
        else passCount++;
    endtask

    task automatic test_underflow();
        int lat; logic bs, ds;
        doOp(8'd0, 8'd1, 1'b0, lat, bs, ds);
        checkCount++;
        if (d !== 8'hFF || borrow_out !== 1'b1)
            $display("[TB] FAIL underflow_0m1: got d=%h bo=%b, want d=ff bo=1", d, borrow_out);
        else passCount++;
        doOp(8'd5, 8'd5, 1'b1, lat, bs, ds);
        checkCount++;
        if (d !== 8'hFF || borrow_out !== 1'b1)
            $display("[TB] FAIL underflow_5m5m1: got d=%h bo=%b, want d=ff bo=1", d, borrow_out);
        else passCount++;
        doOp(8'd5, 8'd5, 1'b0, lat, bs, ds);
        checkCount++;
        if (d !== 8'h00 || borrow_out !== 1'b0)
            $display("[TB] FAIL equal_operands: got d=%h bo=%b, want d=00 bo=0", d, borrow_out);
        else passCount++;
    endtask

    task automatic test_ignored_start();
        int doneCount = 0;
        int holdBad = 0;
        int lat = 0;
        logic [7:0] doneD = '0;
        x = 8'd9; y = 8'd3; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        x = 8'd1; y = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin doneCount++; doneD = d; end
        end
        checkCount++;
        if (doneCount !== 1 || doneD !== 8'd6)
            $display("[TB] FAIL ignored_start: got %0d dones d=%0d, want 1 done d=6", doneCount, doneD);
        else passCount++;
        // Next operation: previous result must be held until its completion edge.
        x = 8'd20; y = 8'd5; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (d !== 8'd6) holdBad++;
        while (done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done !== 1'b1 && d !== 8'd6) holdBad++;
        end
        checkCount++;
        if (holdBad !== 0)
            $display("[TB] FAIL result_hold: got %0d cycles with changed d, want 0", holdBad);
        else passCount++;
        checkCount++;
        if (lat !== 8 || d !== 8'd15)
            $display("[TB] FAIL second_op: got lat=%0d d=%0d, want 8 15", lat, d);
        else passCount++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int doneT[$];
        int busyLow = 0;
        int badD = 0;
        int badGap = 0;
        x = 8'd50; y = 8'd20; borrow_in = 1'b0; start = 1'b1;
        for (int k = 0; k < 45; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                doneT.push_back(k);
                if (d !== 8'd30) badD++;
            end
            if (busy === 1'b0 && doneT.size() > 0) busyLow++;
        end
        start = 1'b0;
        for (int i = 1; i < doneT.size(); i++)
            if (doneT[i] - doneT[i-1] != 10) badGap++;
        checkCount++;
        if (doneT.size() !== 4 || badGap !== 0)
            $display("[TB] FAIL b2b_done_spacing: got %0d dones, %0d bad gaps, want 4 dones 0 bad",
                     doneT.size(), badGap);
        else passCount++;
        checkCount++;
        if (busyLow !== 4)
            $display("[TB] FAIL b2b_busy_low: got %0d idle cycles, want 4", busyLow);
        else passCount++;
        checkCount++;
        if (badD !== 0)
            $display("[TB] FAIL b2b_result: got %0d wrong results, want 0", badD);
        else passCount++;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int lat; logic bs, ds;
        logic [7:0] xv, yv; logic bv;
        for (int n = 0; n < 200; n++) begin
            xv = 8'($urandom); yv = 8'($urandom); bv = 1'($urandom);
            if (n == 0) begin xv = 8'd0;   yv = 8'd255; bv = 1'b1; end
            if (n == 1) begin xv = 8'd255; yv = 8'd0;   bv = 1'b0; end
            if (n == 2) begin xv = 8'd255; yv = 8'd255; bv = 1'b1; end
            doOp(xv, yv, bv, lat, bs, ds);
            checkCount++;
            if (lat !== 8) $display("[TB] FAIL rand_latency: got %0d, want 8", lat);
            else passCount++;
            checkCount++;
            if (d !== refDiff(int'(xv), int'(yv), int'(bv)) ||
                borrow_out !== refBorrow(int'(xv), int'(yv), int'(bv)))
                $display("[TB] FAIL rand_result x=%0d y=%0d b=%0d: got d=%0d bo=%b, want d=%0d bo=%b",
                         xv, yv, bv, d, borrow_out, refDiff(int'(xv), int'(yv), int'(bv)),
                         refBorrow(int'(xv), int'(yv), int'(bv)));
            else passCount++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_midrun_reset();
        test_underflow();
        test_ignored_start();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
